// File: rtl/addsub4_pkg.sv
// Shared definitions for the addsub4 arbiter slice: FSM states, datapath
// width and requester count.
package addsub4_pkg;

    localparam int W    = 4;
    localparam int NREQ = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

endpackage

// File: rtl/addsub4.sv
// 4-bit adder/subtractor: y = a + b (sel=0) or a - b (sel=1), modulo 16.
module addsub4
    import addsub4_pkg::*;
(
    output logic [W-1:0] y,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sel
);

    // Wrap-around is silent; the result is simply truncated to W bits.
    always_comb begin
        y = sel ? (a - b) : (a + b);
    end

endmodule

// File: rtl/addsub4_arb.sv
// Two-requester round-robin front end for one shared addsub4.
// IDLE grants one requester combinationally, RESP holds the registered result
// until the consumer takes it. Optional carry/borrow output resp_c is enabled
// by defining ADDSUB4_ARB_FLAGS_EN.
module addsub4_arb
    import addsub4_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*W-1:0]   req_a,
    input  logic [NREQ*W-1:0]   req_b,
    input  logic [NREQ-1:0]     req_sel,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [W-1:0]        resp_y,
    output logic                resp_id
`ifdef ADDSUB4_ARB_FLAGS_EN
    ,
    output logic                resp_c
`endif
);

    state_t          r_state;
    logic            r_ptr;
    logic            r_valid;
    logic [W-1:0]    r_y;
    logic            r_id;

    logic [NREQ-1:0] w_gnt;
    logic            w_id;
    logic [W-1:0]    w_a;
    logic [W-1:0]    w_b;
    logic            w_sel;
    logic [W-1:0]    w_y;

    // Grant exactly one valid requester in IDLE; the pointer breaks ties.
    // Gated by rst so nothing looks accepted during reset.
    always_comb begin
        w_gnt = '0;
        if (!rst && r_state == ST_IDLE) begin
            case (req_valid)
                2'b01:   w_gnt = 2'b01;
                2'b10:   w_gnt = 2'b10;
                2'b11:   w_gnt = r_ptr ? 2'b10 : 2'b01;
                default: w_gnt = 2'b00;
            endcase
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        w_id  = w_gnt[1];
        w_a   = w_id ? req_a[2*W-1:W] : req_a[W-1:0];
        w_b   = w_id ? req_b[2*W-1:W] : req_b[W-1:0];
        w_sel = w_id ? req_sel[1]     : req_sel[0];
    end

    addsub4 u_addsub4 (
        .y   (w_y),
        .a   (w_a),
        .b   (w_b),
        .sel (w_sel)
    );

`ifdef ADDSUB4_ARB_FLAGS_EN
    logic [W:0] w_sum;
    logic       w_c;
    logic       r_c;

    // Carry-out of the add, or unsigned borrow of the subtract.
    always_comb begin
        w_sum = {1'b0, w_a} + {1'b0, w_b};
        w_c   = w_sel ? (w_a < w_b) : w_sum[W];
    end

    // Flag register tracks resp_y: loaded on acceptance, held otherwise.
    always_ff @(posedge clk) begin
        if (rst)
            r_c <= 1'b0;
        else if (|w_gnt)
            r_c <= w_c;
    end

    assign resp_c = r_c;
`endif

    // FSM: accept in IDLE, hold result in RESP until the response handshake.
    // The handshake cycle never accepts, since req_ready is 0 in RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= 1'b0;
            r_valid <= 1'b0;
            r_y     <= '0;
            r_id    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_gnt) begin
                        r_y     <= w_y;
                        r_id    <= w_id;
                        r_ptr   <= ~w_id;
                        r_valid <= 1'b1;
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        r_valid <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = w_gnt;
    assign resp_valid = r_valid;
    assign resp_y     = r_y;
    assign resp_id    = r_id;

endmodule

// File: doc/addsub4_arb.md
ADDSUB4_ARB -- requirements
Module: addsub4_arb

Interface
REQ-001 No parameters; datapath width is fixed at 4 bits and requester count at 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  2  bit i: requester i presents an operation.
REQ-005 req_ready  output  2  bit i: operation of requester i accepted this cycle.
REQ-006 req_a  input  8  operand A; requester i uses bits [4i+3:4i].
REQ-007 req_b  input  8  operand B; same packing as req_a.
REQ-008 req_sel  input  2  bit i: 0 = add, 1 = subtract, for requester i.
REQ-009 resp_valid  output  1  result held for the consumer.
REQ-010 resp_ready  input  1  consumer takes the result.
REQ-011 resp_y  output  4  result, modulo 16.
REQ-012 resp_id  output  1  index of the requester that owns resp_y.
REQ-013 resp_c  output  1  carry/borrow; present only with ADDSUB4_ARB_FLAGS_EN.

Function
REQ-014 The FSM SHALL have two states: IDLE (able to accept) and RESP (holding a result).
REQ-015 In IDLE, the block SHALL assert req_ready for exactly one requester: the single valid one, or on a tie the one selected by the round-robin pointer; no other req_ready bit SHALL be asserted.
REQ-016 req_ready SHALL depend combinationally on req_valid, the state and the pointer, and SHALL be 0 in RESP.
REQ-017 On acceptance (req_valid[i] && req_ready[i]), the block SHALL register resp_y = a+b (sel=0) or a-b (sel=1), truncated to 4 bits, set resp_id=i, and enter RESP; resp_valid SHALL be 1 in the following cycle (latency 1).
REQ-018 On acceptance the pointer SHALL move to the other requester; it SHALL stay unchanged in all other cycles.
REQ-019 In RESP, resp_y, resp_id and resp_c SHALL be held stable until resp_valid && resp_ready, after which the block SHALL return to IDLE.
REQ-020 No new acceptance SHALL occur in the cycle of the response handshake, so throughput is at most one operation per 2 cycles.
REQ-021 Wrap-around SHALL be silent: for example, 15+1 gives 0 and 0-1 gives 15.
REQ-022 A requester SHALL NOT see req_ready while its req_valid is 0, and a requester dropping req_valid before being accepted SHALL cause no state change.

Reset
REQ-023 While rst=1 at a clock edge: state=IDLE, pointer=0, resp_valid=0, resp_y=0, resp_id=0, resp_c=0.
REQ-024 Reset asserted in RESP SHALL discard the held result without a response handshake.
REQ-025 Because req_ready is combinational, req_ready SHALL be 0 while rst=1.

Configuration
REQ-026 With ADDSUB4_ARB_FLAGS_EN defined, resp_c SHALL exist and be registered with resp_y: the carry-out of a+b when sel=0, and the borrow (1 iff a<b, unsigned) when sel=1.
REQ-027 Without ADDSUB4_ARB_FLAGS_EN, the resp_c port and its register SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-028 The shared package addsub4_pkg SHALL hold the state enum (ST_IDLE, ST_RESP), the width constant 4 and the requester count 2.
REQ-029 Arithmetic SHALL be performed by one instance of the existing addsub4 (ports y, a, b, sel) fed by the granted requester's operand mux; the carry/borrow flag is computed alongside it in addsub4_arb.

Verification
REQ-030 Single request: req0 a=3, b=4, sel=0 -> req_ready=01 in the same cycle; next cycle resp_valid=1, resp_y=7, resp_id=0.
REQ-031 Tie after reset: both valid, req0 a=9 b=2 sel=1, req1 a=1 b=1 sel=0, resp_ready=1 held -> first grant req0 (y=7), second grant req1 (y=2), alternation continues.
REQ-032 Backpressure: resp_ready=0 for 5 cycles after a result -> resp_y and resp_id stable, req_ready=00 throughout; one handshake, then IDLE.
REQ-033 Wrap: 15+1 -> y=0 (resp_c=1 with the flag); 0-1 -> y=15 (resp_c=1 with the flag); 5-3 -> y=2, resp_c=0.
REQ-034 Reset in RESP with result pending -> the next cycle has resp_valid=0, pointer=0, and a subsequent tie grants req0.
REQ-035 Random: 200 cycles of $random operands, sel and valids -> each response matches the reference model, and no requester waits more than 2 grants while valid.
